// File: rtl/alu_share_pkg.sv
// Shared types and defaults for the ALU sharing arbiter.
package alu_share_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned OPW_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
    logic [WIDTH_DEF-1:0] imm;
    logic                 alu_src;
    logic [OPW_DEF-1:0]   op;
  } req_t;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/alu_src_mux.sv
// ALU second-operand source select: register operand or immediate.
module alu_src_mux #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = sel ? d1 : d0;
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; ptr names the requester favoured on a tie.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = valid0 & (~valid1 | ~ptr);
    grant[1] = valid1 & (~valid0 | ptr);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the issue path (0) and the AGU (1).
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned OPW   = OPW_DEF,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_imm,
  input  logic             req0_alu_src,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_imm,
  input  logic             req1_alu_src,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_go,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             ptr_q;
  logic             owner_q;
  logic [2:0]       cnt_q;
  logic [WIDTH-1:0] lat_a_q, lat_b_q, rsp_data_q;
  logic [OPW-1:0]   lat_op_q;

  req_t             req0_s, req1_s, g_req;
  logic [1:0]       grant;
  logic             g_id;
  logic [WIDTH-1:0] src_b;
  logic             accept, capture, owner_ready;

  always_comb begin
    req0_s = '{a: WIDTH_DEF'(req0_a), b: WIDTH_DEF'(req0_b), imm: WIDTH_DEF'(req0_imm),
               alu_src: req0_alu_src, op: OPW_DEF'(req0_op)};
    req1_s = '{a: WIDTH_DEF'(req1_a), b: WIDTH_DEF'(req1_b), imm: WIDTH_DEF'(req1_imm),
               alu_src: req1_alu_src, op: OPW_DEF'(req1_op)};
  end

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (ptr_q),
    .grant  (grant)
  );

  always_comb begin
    g_id  = grant[1];
    g_req = g_id ? req1_s : req0_s;
  end

  alu_src_mux #(.WIDTH(WIDTH)) u_src_mux (
    .sel (g_req.alu_src),
    .d0  (WIDTH'(g_req.b)),
    .d1  (WIDTH'(g_req.imm)),
    .y   (src_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Ready depends only on registered state and request valids, never on rspN_ready.
  always_comb begin
    state_d     = state_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    alu_go      = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    owner_ready = owner_q ? rsp1_ready : rsp0_ready;
    unique case (state_q)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        accept     = |grant;
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        alu_go  = 1'b1;
        alu_a   = lat_a_q;
        alu_b   = lat_b_q;
        alu_op  = lat_op_q;
        capture = (cnt_q == 3'd1);
        if (capture) state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      lat_a_q    <= '0;
      lat_b_q    <= '0;
      lat_op_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        lat_a_q  <= WIDTH'(g_req.a);
        lat_b_q  <= src_b;
        lat_op_q <= OPW'(g_req.op);
        owner_q  <= g_id;
        ptr_q    <= other_id(g_id);
        cnt_q    <= 3'(LAT);
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (capture) rsp_data_q <= alu_result;
    end
  end

  always_comb begin
    rsp_data = rsp_data_q;
    busy     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: LAT=1 instance for arbitration/handshake, LAT=3 instance for latency and reset abort.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // LAT=1 instance signals
  logic        reset;
  logic        r0v, r0r, r0s, r1v, r1r, r1s;
  logic [63:0] r0a, r0b, r0i, r1a, r1b, r1i;
  logic [3:0]  r0o, r1o;
  logic [63:0] aa, ab, ares, rdata;
  logic [3:0]  aop;
  logic        ago, s0v, s0r, s1v, s1r, bsy;

  // LAT=3 instance signals
  logic        x_reset;
  logic        x_r0v, x_r0r, x_r0s, x_r1v, x_r1r, x_r1s;
  logic [63:0] x_r0a, x_r0b, x_r0i, x_r1a, x_r1b, x_r1i;
  logic [3:0]  x_r0o, x_r1o;
  logic [63:0] x_aa, x_ab, x_ares, x_rdata;
  logic [3:0]  x_aop;
  logic        x_ago, x_s0v, x_s0r, x_s1v, x_s1r, x_bsy;

  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  always_comb ares   = alu_model(aa, ab, aop);
  always_comb x_ares = alu_model(x_aa, x_ab, x_aop);

  alu_share_arbiter #(.WIDTH(64), .OPW(4), .LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b), .req0_imm(r0i),
    .req0_alu_src(r0s), .req0_op(r0o),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b), .req1_imm(r1i),
    .req1_alu_src(r1s), .req1_op(r1o),
    .alu_a(aa), .alu_b(ab), .alu_op(aop), .alu_go(ago), .alu_result(ares),
    .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp1_valid(s1v), .rsp1_ready(s1r),
    .rsp_data(rdata), .busy(bsy)
  );

  alu_share_arbiter #(.WIDTH(64), .OPW(4), .LAT(3)) dut3 (
    .clk(clk), .reset(x_reset),
    .req0_valid(x_r0v), .req0_ready(x_r0r), .req0_a(x_r0a), .req0_b(x_r0b), .req0_imm(x_r0i),
    .req0_alu_src(x_r0s), .req0_op(x_r0o),
    .req1_valid(x_r1v), .req1_ready(x_r1r), .req1_a(x_r1a), .req1_b(x_r1b), .req1_imm(x_r1i),
    .req1_alu_src(x_r1s), .req1_op(x_r1o),
    .alu_a(x_aa), .alu_b(x_ab), .alu_op(x_aop), .alu_go(x_ago), .alu_result(x_ares),
    .rsp0_valid(x_s0v), .rsp0_ready(x_s0r), .rsp1_valid(x_s1v), .rsp1_ready(x_s1r),
    .rsp_data(x_rdata), .busy(x_bsy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; x_reset = 1'b1;
    {r0v, r0s, r1v, r1s, s0r, s1r} = '0;
    {r0a, r0b, r0i, r1a, r1b, r1i} = '0;
    r0o = OP_ADD; r1o = OP_ADD;
    {x_r0v, x_r0s, x_r1v, x_r1s, x_s0r, x_s1r} = '0;
    {x_r0a, x_r0b, x_r0i, x_r1a, x_r1b, x_r1i} = '0;
    x_r0o = OP_ADD; x_r1o = OP_ADD;

    tick(); tick();
    chk("rst_busy", 64'(bsy), 64'd0);
    chk("rst_go", 64'(ago), 64'd0);
    chk("rst_rsp_valid", 64'({s0v, s1v}), 64'd0);
    chk("rst_rsp_data", rdata, 64'd0);
    chk("rst_alu_a", aa, 64'd0);
    #3; reset = 1'b0; x_reset = 1'b0;
    tick();

    // 1: req0 alone, register operand, ADD
    r0v = 1'b1; r0a = 64'd5; r0b = 64'd7; r0i = 64'h99; r0s = 1'b0; r0o = OP_ADD;
    #1;
    chk("t1_ready0", 64'(r0r), 64'd1);
    chk("t1_ready1", 64'(r1r), 64'd0);
    tick();
    r0v = 1'b0;
    #1;
    chk("t1_go", 64'(ago), 64'd1);
    chk("t1_alu_a", aa, 64'd5);
    chk("t1_alu_b", ab, 64'd7);
    chk("t1_rsp_early", 64'(s0v), 64'd0);
    tick();
    chk("t1_rsp0_valid", 64'(s0v), 64'd1);
    chk("t1_rsp1_valid", 64'(s1v), 64'd0);
    chk("t1_rsp_data", rdata, 64'd12);
    chk("t1_go_resp", 64'(ago), 64'd0);
    s0r = 1'b1;
    tick();
    s0r = 1'b0;
    chk("t1_idle_valid", 64'(s0v), 64'd0);
    chk("t1_idle_busy", 64'(bsy), 64'd0);

    // 2: req1 alone, immediate operand
    r1v = 1'b1; r1a = 64'h20; r1b = 64'd7; r1i = 64'hFFFF_FFFF_FFFF_FFF0; r1s = 1'b1; r1o = OP_ADD;
    #1;
    chk("t2_ready1", 64'(r1r), 64'd1);
    tick();
    r1v = 1'b0;
    #1;
    chk("t2_alu_b", ab, 64'hFFFF_FFFF_FFFF_FFF0);
    tick();
    chk("t2_rsp1_valid", 64'(s1v), 64'd1);
    chk("t2_rsp0_valid", 64'(s0v), 64'd0);
    chk("t2_rsp_data", rdata, 64'h10);
    s1r = 1'b1;
    tick();
    s1r = 1'b0;
    chk("t2_idle_valid", 64'(s1v), 64'd0);

    // 3: both continuously valid, responses taken immediately
    s0r = 1'b1; s1r = 1'b1;
    r0v = 1'b1; r0b = 64'd4; r0s = 1'b0; r0o = OP_ADD;
    r1v = 1'b1; r1a = 64'd20; r1b = 64'd3; r1s = 1'b0; r1o = OP_SUB;
    for (int i = 0; i < 8; i++) begin
      r0a = 64'(i);
      #1;
      chk("t3_ready0", 64'(r0r), 64'((i % 2) == 0));
      chk("t3_ready1", 64'(r1r), 64'((i % 2) == 1));
      tick();
      tick();
      chk("t3_rsp0_valid", 64'(s0v), 64'((i % 2) == 0));
      chk("t3_rsp1_valid", 64'(s1v), 64'((i % 2) == 1));
      chk("t3_rsp_data", rdata, ((i % 2) == 0) ? 64'(i + 4) : 64'd17);
      tick();
    end

    // 4: owner stalls its response while the other requester waits
    s0r = 1'b0; s1r = 1'b1;
    r0a = 64'd50; r0b = 64'd1; r0o = OP_ADD;
    r1a = 64'd9; r1b = 64'd2; r1o = OP_SUB;
    #1;
    chk("t4_ready0", 64'(r0r), 64'd1);
    chk("t4_ready1", 64'(r1r), 64'd0);
    tick();
    r0v = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 64'(s0v), 64'd1);
      chk("t4_hold_data", rdata, 64'd51);
      chk("t4_hold_ready1", 64'(r1r), 64'd0);
      tick();
    end
    s0r = 1'b1;
    #1;
    chk("t4_no_comb_path", 64'(r1r), 64'd0);
    tick();
    s0r = 1'b0;
    chk("t4_valid_drop", 64'(s0v), 64'd0);
    chk("t4_ready1_after", 64'(r1r), 64'd1);
    tick();
    r1v = 1'b0;
    chk("t4_alu_a", aa, 64'd9);
    chk("t4_alu_op", 64'(aop), 64'(OP_SUB));
    tick();
    chk("t4_rsp1_valid", 64'(s1v), 64'd1);
    chk("t4_rsp1_data", rdata, 64'd7);
    tick();
    s1r = 1'b0;
    chk("t4_idle", 64'(bsy), 64'd0);

    // 6: LAT=3 latency with request inputs toggling during EXEC
    x_r0v = 1'b1; x_r0a = 64'h1234; x_r0b = 64'h11; x_r0i = 64'h100; x_r0s = 1'b1; x_r0o = OP_OR;
    #1;
    chk("t6_ready0", 64'(x_r0r), 64'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t6_go", 64'(x_ago), 64'd1);
      chk("t6_alu_a", x_aa, 64'h1234);
      chk("t6_alu_b", x_ab, 64'h100);
      chk("t6_alu_op", 64'(x_aop), 64'(OP_OR));
      chk("t6_rsp_early", 64'(x_s0v), 64'd0);
      x_r0a = 64'h1111 * 64'(k + 2);
      x_r0s = ~x_r0s;
      x_r0o = OP_XOR;
      x_r0v = k[0];
      tick();
    end
    x_r0v = 1'b1;
    #1;
    chk("t6_rsp_valid", 64'(x_s0v), 64'd1);
    chk("t6_go_off", 64'(x_ago), 64'd0);
    chk("t6_rsp_data", x_rdata, 64'h1334);
    chk("t6_alu_a_off", x_aa, 64'd0);
    chk("t6_no_accept_resp", 64'(x_r0r), 64'd0);
    x_r0v = 1'b0; x_s0r = 1'b1;
    tick();
    x_s0r = 1'b0;
    chk("t6_idle", 64'(x_bsy), 64'd0);

    // 5: asynchronous reset during EXEC aborts the request
    x_r1v = 1'b1; x_r1a = 64'd1; x_r1b = 64'd2; x_r1s = 1'b0; x_r1o = OP_ADD;
    x_s0r = 1'b1; x_s1r = 1'b1;
    tick();
    x_r1v = 1'b0;
    chk("t5_go_before", 64'(x_ago), 64'd1);
    tick();
    #2; x_reset = 1'b1;
    #1;
    chk("t5_busy_async", 64'(x_bsy), 64'd0);
    chk("t5_go_async", 64'(x_ago), 64'd0);
    chk("t5_alu_a_async", x_aa, 64'd0);
    #2; x_reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_no_rsp", 64'({x_s0v, x_s1v}), 64'd0);
      chk("t5_no_busy", 64'(x_bsy), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 64-bit ALU between two requesters: requester 0 is the integer issue path and requester 1 is the load/store address generator.
- Arbitration is round-robin, with a valid/ready handshake on both the request and the response side.
- Latches the operands of the granted request and drives the ALU, including the ALU-source select for the second operand (register or immediate).
- Waits a fixed ALU latency, captures the result and returns it to the owning requester.
- Sits between the requesters and the ALU/operand-mux pair, replacing the direct hard-wired connection.

Parameters:
- WIDTH, 64, datapath width of operands and result.
- OPW, 4, ALU control (operation) code width.
- LAT, 1, ALU latency in cycles from operands valid to result sampled; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a  in  WIDTH  first operand.
- req0_b  in  WIDTH  register second operand.
- req0_imm  in  WIDTH  immediate second operand.
- req0_alu_src  in  1  1 selects imm, 0 selects b.
- req0_op  in  OPW  ALU operation.
- req1_valid, req1_ready, req1_a, req1_b, req1_imm, req1_alu_src, req1_op: same as requester 0.
- alu_a  out  WIDTH  ALU first operand.
- alu_b  out  WIDTH  second operand after source select.
- alu_op  out  OPW  ALU operation.
- alu_go  out  1  ALU operands valid.
- alu_result  in  WIDTH  ALU result.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid  out  1  result available for requester 1.
- rsp1_ready  in  1  requester 1 takes the result.
- rsp_data  out  WIDTH  result; valid when either rspN_valid is high.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, priority pointer=0, counter=0.
  - All latched operands, rsp_data and alu_a/alu_b/alu_op = 0.
  - alu_go, rsp0_valid, rsp1_valid, busy = 0.
  - Any in-flight request or unclaimed result is discarded.
- Clock: one clock; all state updates on the rising edge of clk.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = (state==IDLE) & grantN, combinational; at most one ready is high.
  - Grant rule: only one valid -> grant it. Both valid -> grant the pointer's requester.
  - On valid&ready:
    - latch a, op, and owner id;
    - latch the second operand as alu_src ? imm : b, using the existing ALU-source 2:1 mux;
    - pointer <= other requester;
    - counter <= LAT; go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - alu_go=1; alu_a/alu_b/alu_op driven from the latches, stable for the whole state.
  - Counter decrements each cycle.
  - In the cycle where counter==1: rsp_data <= alu_result; go to RESP.
  - EXEC therefore lasts exactly LAT cycles.
- Outside EXEC: alu_go=0 and alu_a/alu_b/alu_op are forced to 0.
- RESP:
  - rsp<owner>_valid=1; rsp_data is held.
  - When rsp<owner>_ready=1: go to IDLE; the valid drops the next cycle.
  - The non-owner rspN_ready is ignored.
  - No new request is accepted in RESP.
- Latency: accept at cycle t -> rsp_valid first high at t+LAT+1 (LAT=1: t+2).
- Back-to-back throughput: one operation per LAT+2 cycles, given an immediate rsp_ready.
- No combinational path from any rspN_ready to any reqN_ready.
- Request inputs changing while reqN_ready=0 have no effect; operands are sampled only at the handshake.
- Requests held through busy cycles remain pending and are re-arbitrated on return to IDLE.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Reset asserted mid-EXEC or mid-RESP: next observable state is IDLE with all outputs at reset values; no response is ever issued for the aborted request.
- Arithmetic: none inside this block; widths pass through unchanged.

Decomposition:
- Package alu_share_pkg:
  - state enum {IDLE, EXEC, RESP};
  - WIDTH_DEF=64, OPW_DEF=4;
  - typedef req_t {a, b, imm, alu_src, op} (shared by both request ports).
- Sub-module rr_arb2: 2-way round-robin grant from two valids and the pointer. Purely combinational; the pointer register stays in the parent.
- Second-operand selection instantiates the existing 64-bit 2:1 ALU-source mux rather than re-coding it.

Test Plan:
1. Reset, then req0 only: a=5, b=7, src=0, op=ADD; ALU model returns a+b.
   -> req0_ready at t; alu_b=7 at t+1; rsp0_valid at t+2 with rsp_data=12.
2. req1 only: src=1, b=7, imm=0xFFFF_FFFF_FFFF_FFF0.
   -> alu_b=0xFFFF_FFFF_FFFF_FFF0 during EXEC; rsp1_valid, not rsp0_valid.
3. Both valid for 8 operations, rsp_ready tied 1.
   -> grant order 0,1,0,1,...; each response to the correct owner; never both ready high.
4. rsp0_ready held 0 for 5 cycles in RESP with req1 valid.
   -> rsp0_valid and rsp_data stable, req1_ready=0 throughout; req1 granted the cycle after rsp0_ready=1 is sampled.
5. Reset pulsed during EXEC, with LAT=3 in a separate elaboration.
   -> asynchronous clear: busy=0, alu_go=0, no rspN_valid at any later cycle until a new request.
6. LAT=3 sweep: accept at cycle 10.
   -> alu_go high for cycles 11..13; rsp_valid first high at 14; operands stable across EXEC while the request inputs toggle.
